// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module : cpu_ctrl_pkg
// Brief  : Control-bus bit map, sequencer state encodings and opcodes.
// Rev    : 1.0
//==============================================================================
package cpu_ctrl_pkg;

    localparam int c_cs_add      = 0;
    localparam int c_cs_comp     = 1;
    localparam int c_cs_sub      = 2;
    localparam int c_cs_xor      = 3;
    localparam int c_cs_and      = 4;
    localparam int c_cs_or       = 5;
    localparam int c_cs_pc_out   = 6;
    localparam int c_cs_pc_inc   = 7;
    localparam int c_cs_mar_in   = 8;
    localparam int c_cs_mem_rd   = 9;
    localparam int c_cs_mem_wr   = 10;
    localparam int c_cs_ir_in    = 11;
    localparam int c_cs_acc_in   = 12;
    localparam int c_cs_acc_out  = 13;
    localparam int c_cs_tmp_in   = 14;
    localparam int c_cs_tmp_out  = 15;
    localparam int c_cs_b_in     = 16;
    localparam int c_cs_b_out    = 17;
    localparam int c_cs_z_out    = 25;
    localparam int c_cs_flag_out = 26;
    localparam int c_cs_halt     = 27;

    typedef enum logic [2:0] {
        RESET_S = 3'd0,
        F1      = 3'd1,
        F2      = 3'd2,
        E1      = 3'd3,
        E2      = 3'd4,
        E3      = 3'd5,
        HALT    = 3'd6
    } state_t;

    localparam logic [7:0] c_op_nop     = 8'h00;
    localparam logic [7:0] c_op_hlt     = 8'h76;
    localparam logic [7:0] c_op_add     = 8'h80;
    localparam logic [7:0] c_op_sub     = 8'h90;
    localparam logic [7:0] c_op_ana     = 8'hA0;
    localparam logic [7:0] c_op_xra     = 8'hA8;
    localparam logic [7:0] c_op_ora     = 8'hB0;
    localparam logic [7:0] c_op_cmp     = 8'hB8;
    localparam logic [7:0] c_op_mov_ab  = 8'h78;
    localparam logic [7:0] c_op_mov_ba  = 8'h47;
    localparam logic [7:0] c_op_mvi     = 8'h3E;
    localparam logic [7:0] c_op_mov_af  = 8'hF1;

    // ALU ops whose result is written back to A in a second execute cycle
    function automatic logic is_alu_op(input logic [7:0] op);
        return op inside {c_op_add, c_op_sub, c_op_ana, c_op_xra, c_op_ora};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cs_decoder.sv
`default_nettype none
//==============================================================================
// Module : cs_decoder
// Brief  : Pure combinational map of (state, IR) to control word and illegal.
// Rev    : 1.0
//==============================================================================
module cs_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int SZ    = 28,
    parameter int OPC_W = 8
) (
    input  state_t           state,
    input  logic [OPC_W-1:0] ir,
    output logic [SZ-1:0]    cs_bus,
    output logic             illegal
);

    always_comb begin
        cs_bus  = '0;
        illegal = 1'b0;
        unique case (state)
            F1: begin
                cs_bus[c_cs_pc_out] = 1'b1;
                cs_bus[c_cs_mar_in] = 1'b1;
            end
            F2: begin
                cs_bus[c_cs_mem_rd] = 1'b1;
                cs_bus[c_cs_ir_in]  = 1'b1;
                cs_bus[c_cs_pc_inc] = 1'b1;
            end
            E1: begin
                case (ir)
                    c_op_nop, c_op_hlt: ;
                    c_op_add:    begin cs_bus[c_cs_b_out] = 1'b1; cs_bus[c_cs_add]  = 1'b1; end
                    c_op_sub:    begin cs_bus[c_cs_b_out] = 1'b1; cs_bus[c_cs_sub]  = 1'b1; end
                    c_op_ana:    begin cs_bus[c_cs_b_out] = 1'b1; cs_bus[c_cs_and]  = 1'b1; end
                    c_op_xra:    begin cs_bus[c_cs_b_out] = 1'b1; cs_bus[c_cs_xor]  = 1'b1; end
                    c_op_ora:    begin cs_bus[c_cs_b_out] = 1'b1; cs_bus[c_cs_or]   = 1'b1; end
                    c_op_cmp:    begin cs_bus[c_cs_b_out] = 1'b1; cs_bus[c_cs_comp] = 1'b1; end
                    c_op_mov_ab: begin cs_bus[c_cs_b_out] = 1'b1; cs_bus[c_cs_acc_in] = 1'b1; end
                    c_op_mov_ba: begin cs_bus[c_cs_acc_out] = 1'b1; cs_bus[c_cs_b_in] = 1'b1; end
                    c_op_mvi:    begin cs_bus[c_cs_pc_out] = 1'b1; cs_bus[c_cs_mar_in] = 1'b1; end
                    c_op_mov_af: begin cs_bus[c_cs_flag_out] = 1'b1; cs_bus[c_cs_acc_in] = 1'b1; end
                    default:     illegal = 1'b1;
                endcase
            end
            E2: begin
                if (is_alu_op(ir)) begin
                    cs_bus[c_cs_z_out]  = 1'b1;
                    cs_bus[c_cs_acc_in] = 1'b1;
                end else if (ir == c_op_mvi) begin
                    cs_bus[c_cs_mem_rd] = 1'b1;
                    cs_bus[c_cs_acc_in] = 1'b1;
                    cs_bus[c_cs_pc_inc] = 1'b1;
                end
            end
            HALT:    cs_bus[c_cs_halt] = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
//==============================================================================
// Module : control_sequencer
// Brief  : Hardwired T-state sequencer: state register, IR and memory stalls.
// Rev    : 1.0
//==============================================================================
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int SZ    = 28,
    parameter int OPC_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [OPC_W-1:0] ibus,
    input  logic             mem_ready,
    output logic [SZ-1:0]    CS_bus,
    output logic [2:0]       t_state,
    output logic             halted,
    output logic             illegal
);

    state_t           r_state;
    state_t           w_next_state;
    logic [OPC_W-1:0] r_ir;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= RESET_S;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == F2 && mem_ready) begin
                r_ir <= ibus;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            RESET_S: w_next_state = F1;
            F1:      w_next_state = F2;
            F2:      w_next_state = mem_ready ? E1 : F2;
            E1: begin
                if (r_ir == c_op_hlt) begin
                    w_next_state = HALT;
                end else if (is_alu_op(r_ir) || r_ir == c_op_mvi) begin
                    w_next_state = E2;
                end else begin
                    w_next_state = F1;
                end
            end
            // Only the MVI operand read waits on memory in E2
            E2:      w_next_state = (r_ir == c_op_mvi && !mem_ready) ? E2 : F1;
            E3:      w_next_state = F1;
            HALT:    w_next_state = HALT;
            default: w_next_state = F1;
        endcase
    end

    cs_decoder #(
        .SZ    (SZ),
        .OPC_W (OPC_W)
    ) u_cs_decoder (
        .state   (r_state),
        .ir      (r_ir),
        .cs_bus  (CS_bus),
        .illegal (illegal)
    );

    assign t_state = r_state;
    assign halted  = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
//==============================================================================
// Module : tb_control_sequencer
// Brief  : Randomized self-checking bench against an instruction-level model.
// Rev    : 1.0
//==============================================================================
module tb_control_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  ibus = 8'h00;
    logic        mem_ready = 1'b0;
    logic [27:0] CS_bus;
    logic [2:0]  t_state;
    logic        halted;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  t;
        logic [27:0] cs;
        logic        ill;
        logic        rdy;
        logic [7:0]  bus;
    } cyc_t;

    cyc_t exp_q[$];

    logic [7:0] legal_ops [12] = '{8'h00, 8'h76, 8'h80, 8'h90, 8'hA0, 8'hA8,
                                   8'hB0, 8'hB8, 8'h78, 8'h47, 8'h3E, 8'hF1};
    logic [7:0] run_ops   [11] = '{8'h00, 8'h80, 8'h90, 8'hA0, 8'hA8, 8'hB0,
                                   8'hB8, 8'h78, 8'h47, 8'h3E, 8'hF1};

    control_sequencer #(.SZ(28), .OPC_W(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ibus      (ibus),
        .mem_ready (mem_ready),
        .CS_bus    (CS_bus),
        .t_state   (t_state),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [27:0] b(input int n);
        logic [27:0] one = 28'd1;
        return one << n;
    endfunction

    function automatic logic is_legal(input logic [7:0] op);
        foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Control word expected in the first execute cycle for each opcode
    function automatic logic [27:0] e1_cs(input logic [7:0] op);
        case (op)
            8'h80: return b(17) | b(0);
            8'h90: return b(17) | b(2);
            8'hA0: return b(17) | b(4);
            8'hA8: return b(17) | b(3);
            8'hB0: return b(17) | b(5);
            8'hB8: return b(17) | b(1);
            8'h78: return b(17) | b(12);
            8'h47: return b(13) | b(16);
            8'h3E: return b(6)  | b(8);
            8'hF1: return b(26) | b(12);
            default: return 28'd0;
        endcase
    endfunction

    // Expected per-cycle trace of one instruction from F1, with the inputs to drive
    task automatic build(input logic [7:0] op, input int sf2, input int se2);
        cyc_t c;
        exp_q.delete();
        c.t = 3'd1; c.cs = b(6) | b(8); c.ill = 1'b0;
        c.rdy = 1'($urandom); c.bus = 8'($urandom);
        exp_q.push_back(c);
        for (int i = 0; i < sf2; i++) begin
            c.t = 3'd2; c.cs = b(7) | b(9) | b(11); c.ill = 1'b0;
            c.rdy = 1'b0; c.bus = 8'($urandom);
            exp_q.push_back(c);
        end
        c.t = 3'd2; c.cs = b(7) | b(9) | b(11); c.ill = 1'b0; c.rdy = 1'b1; c.bus = op;
        exp_q.push_back(c);
        c.t = 3'd3; c.cs = e1_cs(op); c.ill = !is_legal(op);
        c.rdy = 1'($urandom); c.bus = 8'($urandom);
        exp_q.push_back(c);
        if (op inside {8'h80, 8'h90, 8'hA0, 8'hA8, 8'hB0}) begin
            c.t = 3'd4; c.cs = b(25) | b(12); c.ill = 1'b0;
            c.rdy = 1'($urandom); c.bus = 8'($urandom);
            exp_q.push_back(c);
        end
        if (op == 8'h3E) begin
            for (int i = 0; i <= se2; i++) begin
                c.t = 3'd4; c.cs = b(7) | b(9) | b(12); c.ill = 1'b0;
                c.rdy = (i == se2); c.bus = 8'($urandom);
                exp_q.push_back(c);
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) begin
            ibus = 8'($urandom); mem_ready = 1'($urandom);
            @(negedge CLK);
            checks++;
            if (t_state !== 3'd0 || CS_bus !== 28'd0 || halted !== 1'b0 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: t_state=%0d CS_bus=%h halted=%b illegal=%b, expected 0/0/0/0",
                         t_state, CS_bus, halted, illegal);
            end
        end
        RST_N = 1'b1;
        #1;
        checks++;
        if (t_state !== 3'd0 || CS_bus !== 28'd0) begin
            errors++;
            $display("FAIL reset_release: t_state=%0d CS_bus=%h, expected 0 and 0", t_state, CS_bus);
        end
        @(negedge CLK);
        checks++;
        if (t_state !== 3'd1 || CS_bus !== 28'h140) begin
            errors++;
            $display("FAIL first_f1: t_state=%0d CS_bus=%h, expected 1 and 0000140", t_state, CS_bus);
        end
    endtask

    task automatic test_nop();
        build(8'h00, 0, 0);
        foreach (exp_q[i]) begin
            exp_q[i].rdy = 1'b1; exp_q[i].bus = 8'h00;
        end
        foreach (exp_q[i]) begin
            checks++;
            if (t_state !== exp_q[i].t || CS_bus !== exp_q[i].cs || illegal !== exp_q[i].ill || halted !== 1'b0) begin
                errors++;
                $display("FAIL nop cyc%0d: t_state=%0d CS_bus=%h illegal=%b halted=%b, expected %0d %h %b 0",
                         i, t_state, CS_bus, illegal, halted, exp_q[i].t, exp_q[i].cs, exp_q[i].ill);
            end
            mem_ready = exp_q[i].rdy; ibus = exp_q[i].bus;
            @(negedge CLK);
        end
        checks++;
        if (t_state !== 3'd1) begin
            errors++;
            $display("FAIL nop_return: t_state=%0d, expected 1", t_state);
        end
    endtask

    task automatic test_alu_and_moves();
        foreach (run_ops[k]) begin
            build(run_ops[k], int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            foreach (exp_q[i]) begin
                checks++;
                if (t_state !== exp_q[i].t || CS_bus !== exp_q[i].cs || illegal !== exp_q[i].ill || halted !== 1'b0) begin
                    errors++;
                    $display("FAIL op_%h cyc%0d: t_state=%0d CS_bus=%h illegal=%b halted=%b, expected %0d %h %b 0",
                             run_ops[k], i, t_state, CS_bus, illegal, halted, exp_q[i].t, exp_q[i].cs, exp_q[i].ill);
                end
                mem_ready = exp_q[i].rdy; ibus = exp_q[i].bus;
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_stall_mvi();
        build(8'h3E, 3, 3);
        // Stall cycles present an ALU opcode on the bus; it must not be captured
        foreach (exp_q[i]) if (exp_q[i].t == 3'd2 && !exp_q[i].rdy) exp_q[i].bus = 8'h80;
        foreach (exp_q[i]) begin
            checks++;
            if (t_state !== exp_q[i].t || CS_bus !== exp_q[i].cs || illegal !== exp_q[i].ill || halted !== 1'b0) begin
                errors++;
                $display("FAIL mvi_stall cyc%0d: t_state=%0d CS_bus=%h illegal=%b halted=%b, expected %0d %h %b 0",
                         i, t_state, CS_bus, illegal, halted, exp_q[i].t, exp_q[i].cs, exp_q[i].ill);
            end
            mem_ready = exp_q[i].rdy; ibus = exp_q[i].bus;
            @(negedge CLK);
        end
        checks++;
        if (t_state !== 3'd1) begin
            errors++;
            $display("FAIL mvi_return: t_state=%0d, expected 1", t_state);
        end
    endtask

    task automatic test_illegal();
        logic [7:0] op;
        for (int n = 0; n < 6; n++) begin
            op = 8'hFF;
            if (n > 0) begin
                do op = 8'($urandom); while (is_legal(op));
            end
            build(op, int'($urandom_range(0, 1)), 0);
            foreach (exp_q[i]) begin
                checks++;
                if (t_state !== exp_q[i].t || CS_bus !== exp_q[i].cs || illegal !== exp_q[i].ill || halted !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_%h cyc%0d: t_state=%0d CS_bus=%h illegal=%b halted=%b, expected %0d %h %b 0",
                             op, i, t_state, CS_bus, illegal, halted, exp_q[i].t, exp_q[i].cs, exp_q[i].ill);
                end
                mem_ready = exp_q[i].rdy; ibus = exp_q[i].bus;
                @(negedge CLK);
            end
            checks++;
            if (t_state !== 3'd1 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse_end: t_state=%0d illegal=%b, expected 1 and 0", t_state, illegal);
            end
        end
    endtask

    task automatic test_halt_reset();
        build(8'h76, 1, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (t_state !== exp_q[i].t || CS_bus !== exp_q[i].cs || illegal !== exp_q[i].ill || halted !== 1'b0) begin
                errors++;
                $display("FAIL hlt cyc%0d: t_state=%0d CS_bus=%h illegal=%b halted=%b, expected %0d %h %b 0",
                         i, t_state, CS_bus, illegal, halted, exp_q[i].t, exp_q[i].cs, exp_q[i].ill);
            end
            mem_ready = exp_q[i].rdy; ibus = exp_q[i].bus;
            @(negedge CLK);
        end
        repeat (6) begin
            checks++;
            if (t_state !== 3'd6 || CS_bus !== 28'h8000000 || halted !== 1'b1 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold: t_state=%0d CS_bus=%h halted=%b illegal=%b, expected 6 8000000 1 0",
                         t_state, CS_bus, halted, illegal);
            end
            mem_ready = 1'($urandom); ibus = 8'($urandom);
            @(negedge CLK);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (t_state !== 3'd0 || CS_bus !== 28'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: t_state=%0d CS_bus=%h halted=%b, expected 0 0 0", t_state, CS_bus, halted);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (t_state !== 3'd1 || CS_bus !== 28'h140 || halted !== 1'b0) begin
            errors++;
            $display("FAIL restart_f1: t_state=%0d CS_bus=%h halted=%b, expected 1 0000140 0", t_state, CS_bus, halted);
        end
        // Abort an MVI while its operand read is stalled
        build(8'h3E, 0, 5);
        for (int i = 0; i < 5; i++) begin
            mem_ready = exp_q[i].rdy; ibus = exp_q[i].bus;
            @(negedge CLK);
        end
        checks++;
        if (t_state !== 3'd4 || CS_bus !== (b(7) | b(9) | b(12))) begin
            errors++;
            $display("FAIL mvi_e2_before_abort: t_state=%0d CS_bus=%h, expected 4 %h", t_state, CS_bus, b(7) | b(9) | b(12));
        end
        #3 RST_N = 1'b0;
        #1;
        checks++;
        if (t_state !== 3'd0 || CS_bus !== 28'd0) begin
            errors++;
            $display("FAIL abort_reset: t_state=%0d CS_bus=%h, expected 0 0", t_state, CS_bus);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_random_stream();
        logic [7:0] op;
        for (int n = 0; n < 500; n++) begin
            op = run_ops[$urandom_range(0, 10)];
            build(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            foreach (exp_q[i]) begin
                checks++;
                if (t_state !== exp_q[i].t || CS_bus !== exp_q[i].cs || illegal !== exp_q[i].ill || halted !== 1'b0) begin
                    errors++;
                    $display("FAIL stream%0d_%h cyc%0d: t_state=%0d CS_bus=%h illegal=%b halted=%b, expected %0d %h %b 0",
                             n, op, i, t_state, CS_bus, illegal, halted, exp_q[i].t, exp_q[i].cs, exp_q[i].ill);
                end
                checks++;
                if (!$onehot0(CS_bus[5:0])) begin
                    errors++;
                    $display("FAIL alu_onehot: CS_bus[5:0]=%b, expected at most one bit", CS_bus[5:0]);
                end
                checks++;
                if (!$onehot0({CS_bus[26], CS_bus[25], CS_bus[17], CS_bus[15], CS_bus[13], CS_bus[6]})) begin
                    errors++;
                    $display("FAIL driver_onehot: CS_bus=%h, expected at most one bus driver", CS_bus);
                end
                mem_ready = exp_q[i].rdy; ibus = exp_q[i].bus;
                @(negedge CLK);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_alu_and_moves();
        test_stall_mvi();
        test_illegal();
        test_halt_reset();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
